fetch_stage: RTL and testbench
==============================

# fetch_stage

Fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline. Holds the PC, selects the next PC from sequential, branch, jump and jump-register sources, and presents the fetched instruction to Decode. Consumes `StallF`/`FlushD` from the hazard unit and produces the F-stage predecode fields (`RsF`, `RtF`, `RSDpdF`, `RTDpdF`, `BranchF`, `JumpRegF`) that the hazard unit needs. Detects a halt word, stops fetching, and signals when the pipeline has drained.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that halts fetch
- `DRAIN_CYCLES`, 4, cycles after halt latch before `HaltedOut` rises (1..7)

- `CLK` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `StallF` in 1: hold PC (from hazard unit)
- `FlushD` in 1: load bubble into IF/ID (from hazard unit)
- `PCSrcD` in 1: taken branch resolved in D
- `JumpD` in 1: j/jal in D
- `JumpRegD` in 1: jr in D
- `PCBranchD` in 32: branch target
- `RsValD` in 32: forwarded rs value, jr target
- `InstrF` in 32: instruction memory data for `PCF`, combinational
- `PCF` out 32: fetch address
- `InstrD` out 32: IF/ID instruction
- `PCPlus4D` out 32: IF/ID PC+4
- `ValidD` out 1: IF/ID holds a real instruction
- `RsF`, `RtF` out 5: `InstrF[25:21]`, `InstrF[20:16]`
- `RSDpdF`, `RTDpdF` out 1: F instruction reads rs / rt
- `BranchF`, `JumpRegF` out 1: F instruction is beq/bne / jr
- `HaltedOut` out 1: pipeline drained after halt, sticky

## Operation
- Predecode (combinational from `InstrF`; op=`[31:26]`, fn=`[5:0]`):
  - `BranchF` = op 04 or 05.
  - `JumpRegF` = op 00 and fn 08.
  - `RSDpdF` = 0 for op 02, 03, 0F, and for op 00 with fn 00/02/03; otherwise 1.
  - `RTDpdF` = 1 for op 00 except fn 08, and for op 04, 05, 2B; otherwise 0.
  - All four flags are forced to 0 while `HaltF` is set.
- Next-PC priority:
  1. `HaltF` set: hold.
  2. `JumpRegD`: `RsValD`.
  3. `JumpD`: `{PCPlus4D[31:28], InstrD[25:0], 2'b00}`.
  4. `PCSrcD`: `PCBranchD`.
  5. `StallF`: hold.
  6. Otherwise: `PCF+4`, 32-bit wrap-around.
  - A redirect overrides `StallF`.
- IF/ID update priority:
  1. `HaltF` set, or halt being latched this cycle: bubble.
  2. `FlushD`: bubble.
  3. `StallF` alone: hold.
  4. Otherwise: load `InstrF`, `PCF+4`, `ValidD`=1.
  - Bubble = `InstrD`=0 (sll $0 NOP), `PCPlus4D`=0, `ValidD`=0.
- Halt latch: `HaltF` sets when `InstrF`==`HALT_WORD` and `StallF`=0 and there is no redirect this cycle. The halt word itself never enters D.
- After `HaltF` is set, redirect inputs are ignored (all older instructions have already left D).
- Drain counter (3-bit) increments each cycle while `HaltF`=1, saturating at `DRAIN_CYCLES`. `HaltedOut`=1 when the count equals `DRAIN_CYCLES`.

## Timing
- Reset values (asynchronous, immediate):
  - `PCF`=`RESET_PC`.
  - `InstrD`=0, `PCPlus4D`=0, `ValidD`=0.
  - `HaltF`=0, counter=0, `HaltedOut`=0.
- Reset mid-drain clears everything; fetch restarts at `RESET_PC` on the first edge after release.
- Fetch-to-D latency: 1 cycle.
- Redirect: the target appears on `PCF` one edge after the `*D` strobe. The single wrong-path instruction in F is removed by `FlushD` in the same cycle.
- Stall: `PCF` holds for every cycle `StallF`=1. `InstrF` is re-presented and the predecode stays stable.
- Halt: if the halt word is in F at edge N, `PCF` is frozen from edge N onward and `HaltedOut` rises at edge N+`DRAIN_CYCLES`.
- Simultaneous `StallF` and a redirect: the redirect wins and `PCF` loads the target.

## Test plan
- Reset, then imem returns NOPs: `PCF` = 0, 4, 8, 12 on consecutive edges. `InstrD` lags by one cycle, and `ValidD`=1 from the 2nd edge.
- `InstrF`=0x8C220000 (lw) with `StallF`=`FlushD`=1 for 1 cycle: `PCF` holds one cycle, D gets a bubble (`ValidD`=0), and `RsF`=1, `RtF`=2, `RSDpdF`=1, `RTDpdF`=0.
- `PCSrcD`=1 with `PCBranchD`=0x40 while `StallF`=1: next `PCF`=0x40 and D gets a bubble. Assert `JumpRegD` with `RsValD`=0x80 simultaneously: `PCF`=0x80.
- `InstrD`=0x08000010 and `PCPlus4D`=0x0000_0014 with `JumpD`=1: next `PCF`=0x40.
- Halt word at `PCF`=0x10: `PCF` stays 0x10, `ValidD`=0 thereafter, `HaltedOut` rises exactly 4 edges later, and a later `PCSrcD` pulse has no effect.
- Assert `reset` 2 cycles into drain: all outputs return to reset values immediately, and `PCF`=0 then 4 after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID pipeline register for the 5-stage MIPS pipeline.
// Selects the next PC, predecodes the F instruction for hazard detection, and drains on a halt word.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        StallF,
    input  logic        FlushD,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic        JumpRegD,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] RsValD,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [4:0]  RsF,
    output logic [4:0]  RtF,
    output logic        RSDpdF,
    output logic        RTDpdF,
    output logic        BranchF,
    output logic        JumpRegF,
    output logic        HaltedOut
);

    localparam logic [2:0] DRAIN_MAX = 3'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        IFID_LOAD,
        IFID_HOLD,
        IFID_BUBBLE
    } ifid_op_t;

    logic        halt_f;
    logic [2:0]  drain_cnt;
    logic        redirect;
    logic        halt_latch;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] pc_next;
    ifid_op_t    ifid_op;
    logic [5:0]  op;
    logic [5:0]  fn;

    assign op = InstrF[31:26];
    assign fn = InstrF[5:0];
    assign RsF = InstrF[25:21];
    assign RtF = InstrF[20:16];

    // Dependency flags are suppressed once halted so the hazard unit sees no readers.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        BranchF  = 1'b0;
        JumpRegF = 1'b0;
        RSDpdF   = 1'b1;
        RTDpdF   = 1'b0;
        if (op == 6'h04 || op == 6'h05) BranchF = 1'b1;
        if (op == 6'h00 && fn == 6'h08) JumpRegF = 1'b1;
        if (op == 6'h02 || op == 6'h03 || op == 6'h0F ||
            (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)))
            RSDpdF = 1'b0;
        if ((op == 6'h00 && fn != 6'h08) || op == 6'h04 || op == 6'h05 || op == 6'h2B)
            RTDpdF = 1'b1;
        if (halt_f) begin
            BranchF  = 1'b0;
            JumpRegF = 1'b0;
            RSDpdF   = 1'b0;
            RTDpdF   = 1'b0;
        end
    end

    assign redirect    = !halt_f && (JumpRegD || JumpD || PCSrcD);
    assign halt_latch  = !halt_f && (InstrF == HALT_WORD) && !StallF && !redirect;
    assign pc_plus4    = PCF + 32'd4;
    assign jump_target = {PCPlus4D[31:28], InstrD[25:0], 2'b00};

    always_comb begin
        pc_next = PCF;
        if (halt_f || halt_latch) pc_next = PCF;
        else if (JumpRegD)        pc_next = RsValD;
        else if (JumpD)           pc_next = jump_target;
        else if (PCSrcD)          pc_next = PCBranchD;
        else if (StallF)          pc_next = PCF;
        else                      pc_next = pc_plus4;
    end

    // The halt word is replaced by a bubble so it never reaches Decode.
    always_comb begin
        ifid_op = IFID_LOAD;
        if (halt_f || halt_latch) ifid_op = IFID_BUBBLE;
        else if (FlushD)          ifid_op = IFID_BUBBLE;
        else if (StallF)          ifid_op = IFID_HOLD;
    end

    always_ff @(posedge CLK or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            PCF       <= RESET_PC;
            InstrD    <= 32'h0;
            PCPlus4D  <= 32'h0;
            ValidD    <= 1'b0;
            halt_f    <= 1'b0;
            drain_cnt <= 3'd0;
        end else begin
            PCF <= pc_next;
            case (ifid_op)
                IFID_BUBBLE: begin
                    InstrD   <= 32'h0;
                    PCPlus4D <= 32'h0;
                    ValidD   <= 1'b0;
                end
                IFID_LOAD: begin
                    InstrD   <= InstrF;
                    PCPlus4D <= pc_plus4;
                    ValidD   <= 1'b1;
                end
                default: ;
            endcase
            if (halt_latch) halt_f <= 1'b1;
            if (halt_f && drain_cnt != DRAIN_MAX) drain_cnt <= drain_cnt + 3'd1;
        end
    end

    assign HaltedOut = (drain_cnt == DRAIN_MAX);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: predecode vector table plus multi-cycle sequences
// (sequential fetch, stall/flush, redirects, halt drain, reset mid-drain) with a scoreboard queue.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0, FlushD = 1'b0, PCSrcD = 1'b0, JumpD = 1'b0, JumpRegD = 1'b0;
    logic [31:0] PCBranchD = '0, RsValD = '0, InstrF;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD, RSDpdF, RTDpdF, BranchF, JumpRegF, HaltedOut;
    logic [4:0]  RsF, RtF;

    logic        imem_en = 1'b1;
    logic [31:0] instr_drv = '0;
    logic [31:0] halt_addr = 32'hFFFF_FFF0;

    int n_checks = 0;
    int n_fail = 0;

    // Instruction memory: addi-style word tagged with its address, halt word at halt_addr.
    assign InstrF = !imem_en ? instr_drv :
                    (PCF == halt_addr) ? 32'hFFFF_FFFF : (32'h2000_0000 | PCF);

    fetch_stage dut (
        .CLK(CLK), .reset(reset), .StallF(StallF), .FlushD(FlushD), .PCSrcD(PCSrcD),
        .JumpD(JumpD), .JumpRegD(JumpRegD), .PCBranchD(PCBranchD), .RsValD(RsValD),
        .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RsF(RsF), .RtF(RtF), .RSDpdF(RSDpdF), .RTDpdF(RTDpdF), .BranchF(BranchF),
        .JumpRegF(JumpRegF), .HaltedOut(HaltedOut)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_item_t;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rsd;
        logic        rtd;
        logic        br;
        logic        jr;
    } pd_vec_t;

    sb_item_t sb[$];
    pd_vec_t  vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [31:0] exp);
        sb_item_t it;
        it.name = name;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_item_t it;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got %h expected none", act);
        end else begin
            it = sb.pop_front();
            check(it.name, act, it.exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ctl();
        StallF = 0; FlushD = 0; PCSrcD = 0; JumpD = 0; JumpRegD = 0;
        PCBranchD = '0; RsValD = '0;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        clear_ctl();
        #1;
        check("rst_pcf", PCF, 32'h0);
        check("rst_valid", {31'b0, ValidD}, 32'h0);
        check("rst_halted", {31'b0, HaltedOut}, 32'h0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h8C22_0000, 5'd1,  5'd2, 1'b1, 1'b0, 1'b0, 1'b0}; // lw
        vecs[1]  = '{32'hAC22_0000, 5'd1,  5'd2, 1'b1, 1'b1, 1'b0, 1'b0}; // sw
        vecs[2]  = '{32'h1043_0005, 5'd2,  5'd3, 1'b1, 1'b1, 1'b1, 1'b0}; // beq
        vecs[3]  = '{32'h1443_0005, 5'd2,  5'd3, 1'b1, 1'b1, 1'b1, 1'b0}; // bne
        vecs[4]  = '{32'h03E0_0008, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1}; // jr
        vecs[5]  = '{32'h0002_1080, 5'd0,  5'd2, 1'b0, 1'b1, 1'b0, 1'b0}; // sll
        vecs[6]  = '{32'h0043_0820, 5'd2,  5'd3, 1'b1, 1'b1, 1'b0, 1'b0}; // add
        vecs[7]  = '{32'h0800_0010, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // j
        vecs[8]  = '{32'h0C00_0010, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // jal
        vecs[9]  = '{32'h3C01_0001, 5'd0,  5'd1, 1'b0, 1'b0, 1'b0, 1'b0}; // lui
        vecs[10] = '{32'h0002_1043, 5'd0,  5'd2, 1'b0, 1'b1, 1'b0, 1'b0}; // sra
        vecs[11] = '{32'h0002_1042, 5'd0,  5'd2, 1'b0, 1'b1, 1'b0, 1'b0}; // srl
        vecs[12] = '{32'h2022_0004, 5'd1,  5'd2, 1'b1, 1'b0, 1'b0, 1'b0}; // addi

        // Sequential fetch: InstrD lags PCF by one cycle.
        #1;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            sb_push("seq_pcf", 32'(4 * k));
            sb_push("seq_instrd", 32'h2000_0000 | 32'(4 * (k - 1)));
            sb_push("seq_pcplus4d", 32'(4 * k));
            sb_push("seq_validd", 32'h1);
            step();
            sb_pop(PCF); sb_pop(InstrD); sb_pop(PCPlus4D); sb_pop({31'b0, ValidD});
        end

        // lw held by stall with flush: PC holds, D gets a bubble, then the lw loads.
        imem_en = 1'b0;
        instr_drv = 32'h8C22_0000;
        StallF = 1; FlushD = 1;
        #1;
        check("lw_rsf", {27'b0, RsF}, 32'd1);
        check("lw_rtf", {27'b0, RtF}, 32'd2);
        check("lw_rsd", {31'b0, RSDpdF}, 32'd1);
        check("lw_rtd", {31'b0, RTDpdF}, 32'd0);
        sb_push("stall_pcf", 32'h10);
        sb_push("stall_validd", 32'h0);
        sb_push("stall_instrd", 32'h0);
        step();
        sb_pop(PCF); sb_pop({31'b0, ValidD}); sb_pop(InstrD);
        StallF = 0; FlushD = 0;
        sb_push("unstall_pcf", 32'h14);
        sb_push("unstall_instrd", 32'h8C22_0000);
        sb_push("unstall_pcplus4d", 32'h14);
        sb_push("unstall_validd", 32'h1);
        step();
        sb_pop(PCF); sb_pop(InstrD); sb_pop(PCPlus4D); sb_pop({31'b0, ValidD});

        // Predecode table, PC held by stall.
        StallF = 1;
        for (int i = 0; i < 13; i++) begin
            instr_drv = vecs[i].instr;
            sb_push($sformatf("pd%0d_rs", i),  {27'b0, vecs[i].rs});
            sb_push($sformatf("pd%0d_rt", i),  {27'b0, vecs[i].rt});
            sb_push($sformatf("pd%0d_rsd", i), {31'b0, vecs[i].rsd});
            sb_push($sformatf("pd%0d_rtd", i), {31'b0, vecs[i].rtd});
            sb_push($sformatf("pd%0d_br", i),  {31'b0, vecs[i].br});
            sb_push($sformatf("pd%0d_jr", i),  {31'b0, vecs[i].jr});
            #2;
            sb_pop({27'b0, RsF}); sb_pop({27'b0, RtF}); sb_pop({31'b0, RSDpdF});
            sb_pop({31'b0, RTDpdF}); sb_pop({31'b0, BranchF}); sb_pop({31'b0, JumpRegF});
        end
        check("pd_stall_pc_hold", PCF, 32'h14);

        // Branch overrides stall; jr beats a simultaneous branch.
        step();
        instr_drv = 32'h0;
        StallF = 1; FlushD = 1; PCSrcD = 1; PCBranchD = 32'h40;
        sb_push("br_pcf", 32'h40);
        sb_push("br_validd", 32'h0);
        step();
        sb_pop(PCF); sb_pop({31'b0, ValidD});
        JumpRegD = 1; RsValD = 32'h80;
        sb_push("jr_pcf", 32'h80);
        step();
        sb_pop(PCF);
        clear_ctl();

        // j: target built from PCPlus4D[31:28] and InstrD[25:0].
        JumpRegD = 1; RsValD = 32'h10; FlushD = 1;
        step();
        clear_ctl();
        instr_drv = 32'h0800_0010;
        sb_push("j_instrd", 32'h0800_0010);
        sb_push("j_pcplus4d", 32'h14);
        step();
        sb_pop(InstrD); sb_pop(PCPlus4D);
        JumpD = 1; FlushD = 1;
        sb_push("j_pcf", 32'h40);
        sb_push("j_validd", 32'h0);
        step();
        sb_pop(PCF); sb_pop({31'b0, ValidD});
        clear_ctl();

        // Halt at 0x10: PC frozen, bubbles, HaltedOut 4 edges later, redirect ignored.
        imem_en = 1'b1;
        halt_addr = 32'h10;
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check("pre_halt_pcf", PCF, 32'h10);
        check("pre_halt_rsd", {31'b0, RSDpdF}, 32'h1);
        sb_push("halt_pcf", 32'h10);
        sb_push("halt_validd", 32'h0);
        sb_push("halt_instrd", 32'h0);
        sb_push("halt_rsd_forced", 32'h0);
        step();
        sb_pop(PCF); sb_pop({31'b0, ValidD}); sb_pop(InstrD); sb_pop({31'b0, RSDpdF});
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) begin
                PCSrcD = 1; PCBranchD = 32'h40;
            end else begin
                PCSrcD = 0;
            end
            sb_push($sformatf("drain%0d_pcf", k), 32'h10);
            sb_push($sformatf("drain%0d_validd", k), 32'h0);
            sb_push($sformatf("drain%0d_halted", k), (k >= 4) ? 32'h1 : 32'h0);
            step();
            sb_pop(PCF); sb_pop({31'b0, ValidD}); sb_pop({31'b0, HaltedOut});
        end
        clear_ctl();

        // Reset two cycles into drain, then restart.
        do_reset();
        for (int k = 0; k < 7; k++) step();
        reset = 1'b1;
        halt_addr = 32'hFFFF_FFF0;
        #1;
        check("mid_rst_pcf", PCF, 32'h0);
        check("mid_rst_instrd", InstrD, 32'h0);
        check("mid_rst_pcplus4d", PCPlus4D, 32'h0);
        check("mid_rst_validd", {31'b0, ValidD}, 32'h0);
        check("mid_rst_halted", {31'b0, HaltedOut}, 32'h0);
        #2;
        reset = 1'b0;
        step();
        check("restart_pcf", PCF, 32'h4);
        check("restart_validd", {31'b0, ValidD}, 32'h1);
        for (int k = 0; k < 5; k++) step();
        check("restart_pcf_run", PCF, 32'h18);
        check("restart_halted", {31'b0, HaltedOut}, 32'h0);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
